// File: rtl/mttkrp_pkg.sv
// Shared widths, typedefs and helpers for the MTTKRP compute array and its factor row server.
package mttkrp_pkg;
   localparam int TENSOR_DIMENSIONS      = 3;
   localparam int NM                     = TENSOR_DIMENSIONS - 1;
   localparam int FACTOR_MATRIX_WIDTH    = 32;
   localparam int RANK_FACTOR_MATRIX     = 16;
   localparam int MODE_TENSOR_ADDR_WIDTH = 16;
   localparam int NUM_ROWS               = 1024;
   localparam int NUM_COMPUTE_UNITS      = 320;
   localparam int CW                     = $clog2(NUM_COMPUTE_UNITS) + 1;
   localparam int REQ_FIFO_DEPTH         = 8;
   localparam int RAM_AW                 = $clog2(NUM_ROWS);
   localparam int MODE_W                 = $clog2(NM) + 1;
   localparam int LVL_W                  = $clog2(REQ_FIFO_DEPTH) + 1;

   typedef logic [RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0] factor_row_t;
   typedef logic [CW-1:0]                                          compute_id_t;
   typedef logic [MODE_TENSOR_ADDR_WIDTH-1:0]                      row_addr_t;

   localparam compute_id_t IDLE_ID = compute_id_t'(NUM_COMPUTE_UNITS);
   localparam logic [MODE_TENSOR_ADDR_WIDTH:0] ROW_LIMIT = (MODE_TENSOR_ADDR_WIDTH+1)'(NUM_ROWS);

   typedef struct packed {
      row_addr_t [NM-1:0] addr;
      compute_id_t        id;
   } req_t;

   // Extra top bit keeps the compare correct even when NUM_ROWS == 2^addr_width.
   function automatic logic row_in_range(input row_addr_t a);
      return {1'b0, a} < ROW_LIMIT;
   endfunction
endpackage

// File: rtl/factor_row_ram.sv
// Single-port factor row RAM: registered read, write wins over read in the same cycle.
module factor_row_ram
   import mttkrp_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [RAM_AW-1:0] i_addr,
   input  factor_row_t       i_wdata,
   output factor_row_t       o_rdata
);
   factor_row_t r_mem [NUM_ROWS];
   factor_row_t r_rdata;

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
      else if (i_re)
         r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/factor_row_server.sv
// Queues compute-array row requests, reads one row per mode from the factor RAMs and
// returns them tagged with the requester id, three cycles after acceptance when unstalled.
module factor_row_server
   import mttkrp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NM-1:0]        req_addr_en,
   input  row_addr_t [NM-1:0]   req_addr,
   input  compute_id_t          req_compute_id,
   output logic                 req_ack,
   input  logic                 load_en,
   input  logic [MODE_W-1:0]    load_mode,
   input  row_addr_t            load_addr,
   input  factor_row_t          load_data,
   output logic [NM-1:0]        rsp_en,
   output factor_row_t [NM-1:0] rsp_data,
   output compute_id_t          rsp_compute_id,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 addr_err
);
   localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);

   req_t                 r_fifo [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]     r_count;
   logic [1:0]           r_vld_pipe;
   compute_id_t          r_s1_id;
   logic [NM-1:0]        r_s1_oor;
   logic                 r_addr_err;
   logic                 w_full, w_empty, w_pop, w_load_ok;
   req_t                 w_head;
   logic [NM-1:0]        w_oor;
   factor_row_t [NM-1:0] w_rdata;

   assign w_full    = (r_count == LVL_W'(REQ_FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign req_ack   = rst & (&req_addr_en) & (req_compute_id != IDLE_ID) & ~w_full;
   // Loads own every RAM port for the cycle, so they stall issue.
   assign w_pop     = ~w_empty & ~load_en;
   assign w_head    = r_fifo[r_rd_ptr];
   assign w_load_ok = (load_mode < MODE_W'(NM)) & row_in_range(load_addr);

   always_ff @(posedge clk) begin
      if (req_ack)
         r_fifo[r_wr_ptr] <= req_t'({req_addr, req_compute_id});
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (req_ack) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + LVL_W'(req_ack) - LVL_W'(w_pop);
      end
   end

   for (genvar m = 0; m < NM; m++) begin : g_mode
      logic w_we;
      assign w_oor[m] = ~row_in_range(w_head.addr[m]);
      assign w_we     = load_en & w_load_ok & (load_mode == MODE_W'(m));
      factor_row_ram u_ram (
         .clk     (clk),
         .i_we    (w_we),
         .i_re    (w_pop),
         .i_addr  (load_en ? load_addr[RAM_AW-1:0] : w_head.addr[m][RAM_AW-1:0]),
         .i_wdata (load_data),
         .o_rdata (w_rdata[m])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) r_vld_pipe <= '0;
      else      r_vld_pipe <= {r_vld_pipe[0], w_pop};
   end

   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_s1_id  <= w_head.id;
         r_s1_oor <= w_oor;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_data       <= '0;
         rsp_compute_id <= IDLE_ID;
      end else if (r_vld_pipe[0]) begin
         rsp_compute_id <= r_s1_id;
         for (int m = 0; m < NM; m++)
            rsp_data[m] <= r_s1_oor[m] ? '0 : w_rdata[m];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         r_addr_err <= 1'b0;
      else if ((w_pop & |w_oor) | (load_en & ~w_load_ok))
         r_addr_err <= 1'b1;
   end

   assign rsp_en     = {NM{r_vld_pipe[1]}};
   assign fifo_level = r_count;
   assign addr_err   = r_addr_err;
endmodule

// File: tb/tb_factor_row_server.sv
// Randomized bench for factor_row_server against a transaction-queue reference model.
module tb_factor_row_server;
   import mttkrp_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NM-1:0]        req_addr_en = '0;
   row_addr_t [NM-1:0]   req_addr = '0;
   compute_id_t          req_compute_id = IDLE_ID;
   logic                 req_ack;
   logic                 load_en = 1'b0;
   logic [MODE_W-1:0]    load_mode = '0;
   row_addr_t            load_addr = '0;
   factor_row_t          load_data = '0;
   logic [NM-1:0]        rsp_en;
   factor_row_t [NM-1:0] rsp_data;
   compute_id_t          rsp_compute_id;
   logic [LVL_W-1:0]     fifo_level;
   logic                 addr_err;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      row_addr_t [NM-1:0] a;
      compute_id_t        id;
   } mreq_t;

   mreq_t                mq[$];
   factor_row_t          mem [NM][NUM_ROWS];
   bit                   s1_v = 1'b0;
   compute_id_t          s1_id;
   factor_row_t [NM-1:0] s1_d;
   bit                   e_en = 1'b0;
   compute_id_t          e_id = IDLE_ID;
   factor_row_t [NM-1:0] e_d = '0;
   bit                   e_err = 1'b0;

   factor_row_server dut (
      .clk            (clk),
      .rst            (rst),
      .req_addr_en    (req_addr_en),
      .req_addr       (req_addr),
      .req_compute_id (req_compute_id),
      .req_ack        (req_ack),
      .load_en        (load_en),
      .load_mode      (load_mode),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .rsp_en         (rsp_en),
      .rsp_data       (rsp_data),
      .rsp_compute_id (rsp_compute_id),
      .fifo_level     (fifo_level),
      .addr_err       (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic factor_row_t rnd_row();
      factor_row_t r;
      for (int i = 0; i < RANK_FACTOR_MATRIX; i++) r[i] = $urandom;
      return r;
   endfunction

   function automatic factor_row_t ramp_row(input int base);
      factor_row_t r;
      for (int i = 0; i < RANK_FACTOR_MATRIX; i++) r[i] = 32'(base + i);
      return r;
   endfunction

   task automatic drv_req(input logic [NM-1:0] en, input int a0, input int a1, input int id);
      req_addr_en    = en;
      req_addr[0]    = row_addr_t'(a0);
      req_addr[1]    = row_addr_t'(a1);
      req_compute_id = compute_id_t'(id);
   endtask

   task automatic drv_load(input logic en, input int mode, input int addr, input factor_row_t d);
      load_en   = en;
      load_mode = MODE_W'(mode);
      load_addr = row_addr_t'(addr);
      load_data = d;
   endtask

   // One clock: check outputs of the last edge and the live ack, then advance the model.
   task automatic tick();
      bit    ack;
      mreq_t r;
      @(negedge clk);
      ack = rst && (&req_addr_en) && (req_compute_id != IDLE_ID) && (mq.size() < REQ_FIFO_DEPTH);
      chk("req_ack", 512'(req_ack), 512'(ack));
      chk("rsp_en", 512'(rsp_en), 512'({NM{e_en}}));
      chk("rsp_compute_id", 512'(rsp_compute_id), 512'(e_id));
      chk("rsp_data0", rsp_data[0], e_d[0]);
      chk("rsp_data1", rsp_data[1], e_d[1]);
      chk("fifo_level", 512'(fifo_level), 512'(mq.size()));
      chk("addr_err", 512'(addr_err), 512'(e_err));
      @(posedge clk);
      if (!rst) begin
         mq.delete();
         s1_v  = 1'b0;
         e_en  = 1'b0;
         e_id  = IDLE_ID;
         e_d   = '0;
         e_err = 1'b0;
      end else begin
         e_en = s1_v;
         if (s1_v) begin
            e_id = s1_id;
            e_d  = s1_d;
         end
         s1_v = 1'b0;
         if (mq.size() > 0 && !load_en) begin
            r     = mq.pop_front();
            s1_v  = 1'b1;
            s1_id = r.id;
            for (int m = 0; m < NM; m++) begin
               if (int'(r.a[m]) >= NUM_ROWS) begin
                  s1_d[m] = '0;
                  e_err   = 1'b1;
               end else begin
                  s1_d[m] = mem[m][r.a[m]];
               end
            end
         end
         if (load_en) begin
            if (int'(load_mode) >= NM || int'(load_addr) >= NUM_ROWS) e_err = 1'b1;
            else mem[load_mode][load_addr] = load_data;
         end
         if (ack) mq.push_back('{a: req_addr, id: req_compute_id});
      end
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      repeat (2) tick();
      rst = 1'b1;
      tick();

      for (int m = 0; m < NM; m++)
         for (int a = 0; a < NUM_ROWS; a++) begin
            drv_load(1'b1, m, a, rnd_row());
            tick();
         end
      drv_load(1'b0, 0, 0, '0);

      // Basic request with known row contents.
      drv_load(1'b1, 0, 5, ramp_row(0));   tick();
      drv_load(1'b1, 1, 9, ramp_row(100)); tick();
      drv_load(1'b0, 0, 0, '0);
      drv_req(2'b11, 5, 9, 17); tick();
      drv_req(2'b00, 0, 0, 0);
      repeat (4) tick();

      // Partial enable and idle id are ignored.
      drv_req(2'b01, 1, 1, 3);   tick();
      drv_req(2'b11, 1, 1, 320); tick();
      drv_req(2'b00, 0, 0, 0);
      repeat (3) tick();

      // Load stall fills the queue, then it drains in order.
      for (int i = 0; i < 12; i++) begin
         drv_load(1'b1, i % 2, 200 + i, rnd_row());
         drv_req(2'b11, 10 + i, 20 + i, 50 + i);
         tick();
      end
      drv_load(1'b0, 0, 0, '0);
      drv_req(2'b00, 0, 0, 0);
      repeat (12) tick();

      // Out-of-range mode-0 address; error stays set.
      drv_req(2'b11, 1024, 3, 42); tick();
      drv_req(2'b00, 0, 0, 0);
      repeat (6) tick();

      // Write then read the same row on the following cycle.
      drv_load(1'b1, 0, 7, ramp_row(7000)); tick();
      drv_load(1'b0, 0, 0, '0);
      drv_req(2'b11, 7, 7, 99); tick();
      drv_req(2'b00, 0, 0, 0);
      repeat (4) tick();

      // Reset with four requests queued behind a load stall.
      for (int i = 0; i < 4; i++) begin
         drv_load(1'b1, 1, 300 + i, rnd_row());
         drv_req(2'b11, 30 + i, 40 + i, 60 + i);
         tick();
      end
      drv_load(1'b0, 0, 0, '0);
      drv_req(2'b00, 0, 0, 0);
      rst = 1'b0; tick();
      rst = 1'b1;
      repeat (6) tick();

      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         drv_req(($urandom_range(0, 7) == 0) ? NM'($urandom) : 2'b11,
                 ($urandom_range(0, 19) == 0) ? $urandom_range(1024, 65535) : $urandom_range(0, 1023),
                 ($urandom_range(0, 19) == 0) ? $urandom_range(1024, 65535) : $urandom_range(0, 1023),
                 ($urandom_range(0, 15) == 0) ? 320 : $urandom_range(0, 319));
         drv_load($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1),
                  ($urandom_range(0, 19) == 0) ? $urandom_range(1024, 65535) : $urandom_range(0, 1023),
                  rnd_row());
         tick();
      end
      rst = 1'b1;
      drv_load(1'b0, 0, 0, '0);
      drv_req(2'b00, 0, 0, 0);
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
